idt_vector_sequencer: RTL and testbench



---
 rtl/idt_vector_sequencer_if.sv | 29 ++
 rtl/idt_vector_sequencer.sv | 152 +++++++++++++++
 tb/tb_idt_vector_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/idt_vector_sequencer_if.sv
// Stimulus/response bus between a run controller and idt_vector_sequencer.
// master drives run control and DUT response; slave is the sequencer.
interface idt_vector_sequencer_if #(
  parameter int IN_W  = 86,
  parameter int Y_W   = 81,
  parameter int IDX_W = 16
) ();
  logic             start;
  logic             abort;
  logic [IN_W-1:0]  seed;
  logic [Y_W-1:0]   golden;
  logic [IN_W-1:0]  stim;
  logic [Y_W-1:0]   y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [Y_W-1:0]   sig;
  logic [IDX_W-1:0] vec_idx;

  modport master (
    output start, abort, seed, golden, y,
    input  stim, busy, done, pass, sig, vec_idx
  );

  modport slave (
    input  start, abort, seed, golden, y,
    output stim, busy, done, pass, sig, vec_idx
  );
endinterface

// File: rtl/idt_vector_sequencer.sv
// Drives a zero vector then LFSR vectors into a DUT and compacts its responses
// into a MISR signature checked against golden. IDT_TRACE_EN adds a capture trace.
module idt_vector_sequencer #(
  parameter int IN_W     = 86,
  parameter int Y_W      = 81,
  parameter int NUM_VEC  = 22,
  parameter int HOLD_CYC = 2,
  parameter int IDX_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  idt_vector_sequencer_if.slave bus
`ifdef IDT_TRACE_EN
  ,
  output logic                  trace_valid,
  output logic [Y_W-1:0]        trace_data
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] VEC_LAST  = IDX_W'(NUM_VEC - 1);

  function automatic logic [IN_W-1:0] lfsr_next(input logic [IN_W-1:0] l);
    logic fb;
    fb = l[IN_W-1] ^ l[IN_W/2] ^ l[0];
    return {l[IN_W-2:0], fb};
  endfunction

  function automatic logic [Y_W-1:0] misr_next(input logic [Y_W-1:0] s, input logic [Y_W-1:0] d);
    return {s[Y_W-2:0], s[Y_W-1]} ^ d;
  endfunction

  state_t           state_r;
  logic [IN_W-1:0]  lfsr_r;
  logic [IN_W-1:0]  stim_r;
  logic [Y_W-1:0]   sig_r;
  logic [IDX_W-1:0] vec_idx_r;
  logic [7:0]       hold_cnt_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;

  logic             capture_s;
  logic [Y_W-1:0]   sig_next_s;
  logic [IN_W-1:0]  seed_fix_s;

  // Capture strobe, next signature and zero-seed substitution.
  always_comb begin
    capture_s  = (state_r == HOLD) && (hold_cnt_r == HOLD_LAST);
    sig_next_s = misr_next(sig_r, bus.y);
    if (bus.seed == {IN_W{1'b0}}) begin
      seed_fix_s = IN_W'(1'b1);
    end else begin
      seed_fix_s = bus.seed;
    end
  end

  // Run FSM with all outputs registered; abort overrides every other event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      lfsr_r     <= {IN_W{1'b0}};
      stim_r     <= {IN_W{1'b0}};
      sig_r      <= {Y_W{1'b0}};
      vec_idx_r  <= {IDX_W{1'b0}};
      hold_cnt_r <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
    end else if (bus.abort) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (bus.start) begin
            state_r <= LOAD;
            lfsr_r  <= seed_fix_s;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
          end
        end
        LOAD: begin
          stim_r     <= {IN_W{1'b0}};
          vec_idx_r  <= {IDX_W{1'b0}};
          sig_r      <= {Y_W{1'b0}};
          hold_cnt_r <= 8'd0;
          state_r    <= HOLD;
        end
        HOLD: begin
          if (capture_s) begin
            sig_r <= sig_next_s;
            if (vec_idx_r == VEC_LAST) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              pass_r  <= (sig_next_s == bus.golden);
            end else begin
              stim_r     <= lfsr_r;
              lfsr_r     <= lfsr_next(lfsr_r);
              vec_idx_r  <= vec_idx_r + IDX_W'(1'b1);
              hold_cnt_r <= 8'd0;
            end
          end else begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          pass_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef IDT_TRACE_EN
  // Trace strobe and data appear together the clock after each capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_valid <= 1'b0;
      trace_data  <= {Y_W{1'b0}};
    end else if (bus.abort) begin
      trace_valid <= 1'b0;
    end else begin
      trace_valid <= capture_s;
      if (capture_s) begin
        trace_data <= bus.y;
      end
    end
  end
`endif

  assign bus.stim    = stim_r;
  assign bus.sig     = sig_r;
  assign bus.vec_idx = vec_idx_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.pass    = pass_r;

endmodule

// File: tb/tb_idt_vector_sequencer.sv
// Directed bench: three small sequencer instances covering sequence, MISR,
// hold timing, abort and asynchronous reset.
module tb_idt_vector_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  idt_vector_sequencer_if #(.IN_W(8), .Y_W(8), .IDX_W(16)) ia ();
  idt_vector_sequencer_if #(.IN_W(8), .Y_W(8), .IDX_W(16)) ib ();
  idt_vector_sequencer_if #(.IN_W(8), .Y_W(8), .IDX_W(16)) ic ();

  assign ia.y = ia.stim;
  assign ic.y = ic.stim;

`ifdef IDT_TRACE_EN
  logic       a_tv, b_tv, c_tv;
  logic [7:0] a_td, b_td, c_td;
  int         tcount = 0;
  logic [7:0] tlog [16];

  always @(negedge clk) begin
    if (a_tv === 1'b1 && tcount < 16) begin
      tlog[tcount] <= a_td;
      tcount       <= tcount + 1;
    end
  end
`endif

  idt_vector_sequencer #(.IN_W(8), .Y_W(8), .NUM_VEC(6), .HOLD_CYC(1), .IDX_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia)
`ifdef IDT_TRACE_EN
    , .trace_valid(a_tv), .trace_data(a_td)
`endif
  );

  idt_vector_sequencer #(.IN_W(8), .Y_W(8), .NUM_VEC(3), .HOLD_CYC(1), .IDX_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
`ifdef IDT_TRACE_EN
    , .trace_valid(b_tv), .trace_data(b_td)
`endif
  );

  idt_vector_sequencer #(.IN_W(8), .Y_W(8), .NUM_VEC(4), .HOLD_CYC(3), .IDX_W(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ic)
`ifdef IDT_TRACE_EN
    , .trace_valid(c_tv), .trace_data(c_td)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  logic [7:0] exp_a [6];
  logic [7:0] exp_b [3];
  logic [7:0] exp_c [4];

  initial begin
    exp_a = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
    exp_b = '{8'h01, 8'h03, 8'h07};
    exp_c = '{8'h00, 8'h80, 8'h01, 8'h03};
    rst_n = 1'b0;
    ia.start = 1'b0; ia.abort = 1'b0; ia.seed = 8'h00; ia.golden = 8'h00;
    ib.start = 1'b0; ib.abort = 1'b0; ib.seed = 8'h00; ib.golden = 8'h00; ib.y = 8'h00;
    ic.start = 1'b0; ic.abort = 1'b0; ic.seed = 8'h00; ic.golden = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stim", 32'(ia.stim), 32'h0);
    check("rst_sig", 32'(ia.sig), 32'h0);
    check("rst_idx", 32'(ia.vec_idx), 32'h0);
    check("rst_flags", {29'd0, ia.busy, ia.done, ia.pass}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: seed 01, y = stim; final signature 15.
    ia.seed = 8'h01; ia.golden = 8'h15; ia.start = 1'b1;
    @(posedge clk); #1;
    ia.start = 1'b0;
    check("a_busy_load", 32'(ia.busy), 32'h1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("a_stim", 32'(ia.stim), 32'(exp_a[k]));
      check("a_idx", 32'(ia.vec_idx), k);
      check("a_not_done", 32'(ia.done), 32'h0);
    end
    @(posedge clk); #1;
    check("a_done", {30'd0, ia.done, ia.busy}, 32'h2);
    check("a_sig", 32'(ia.sig), 32'h15);
    check("a_pass", 32'(ia.pass), 32'h1);
`ifdef IDT_TRACE_EN
    @(negedge clk); #1;
    check("trace_count", tcount, 6);
    for (int k = 0; k < 6; k++) begin
      check("trace_data", 32'(tlog[k]), 32'(exp_a[k]));
    end
`endif

    // Test 3: seed 0 behaves as seed 1; start in DONE clears done/pass.
    ia.seed = 8'h00; ia.start = 1'b1;
    @(posedge clk); #1;
    ia.start = 1'b0;
    check("a0_clr", {30'd0, ia.done, ia.pass}, 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("a0_stim", 32'(ia.stim), 32'(exp_a[k]));
    end
    @(posedge clk); #1;
    check("a0_sig", 32'(ia.sig), 32'h15);
    check("a0_pass", {30'd0, ia.done, ia.pass}, 32'h3);

    // Test 2: y held at 01, signature 01,03,07.
    ib.y = 8'h01; ib.golden = 8'h07; ib.seed = 8'h5A; ib.start = 1'b1;
    @(posedge clk); #1;
    ib.start = 1'b0;
    @(posedge clk); #1;
    check("b_sig_load", 32'(ib.sig), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("b_sig", 32'(ib.sig), 32'(exp_b[k]));
    end
    check("b_pass", {30'd0, ib.done, ib.pass}, 32'h3);
    ib.golden = 8'h00;
    @(posedge clk); #1;
    check("b_pass_hold", 32'(ib.pass), 32'h1);
    ib.golden = 8'h06; ib.start = 1'b1;
    @(posedge clk); #1;
    ib.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("b_fail_done", {30'd0, ib.done, ib.pass}, 32'h2);

    // Test 4: HOLD_CYC=3, NUM_VEC=4, done 13 clocks after LOAD.
    ic.seed = 8'h80; ic.golden = 8'h03; ic.start = 1'b1;
    @(posedge clk); #1;
    ic.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int h = 0; h < 3; h++) begin
        @(posedge clk); #1;
        check("c_stim", 32'(ic.stim), 32'(exp_c[k]));
        check("c_not_done", 32'(ic.done), 32'h0);
      end
    end
    @(posedge clk); #1;
    check("c_done", {30'd0, ic.done, ic.busy}, 32'h2);
    check("c_sig", 32'(ic.sig), 32'h03);
    check("c_pass", 32'(ic.pass), 32'h1);

    // Test 5: abort with start at vec_idx 2, then a clean rerun.
    ic.start = 1'b1;
    @(posedge clk); #1;
    ic.start = 1'b0;
    for (int i = 0; i < 40 && ic.vec_idx != 16'd2; i++) begin
      @(posedge clk); #1;
    end
    check("c_reach_idx2", 32'(ic.vec_idx), 32'h2);
    ic.abort = 1'b1; ic.start = 1'b1;
    @(posedge clk); #1;
    ic.abort = 1'b0; ic.start = 1'b0;
    check("c_abort", {29'd0, ic.busy, ic.done, ic.pass}, 32'h0);
    @(posedge clk); #1;
    check("c_abort_idle", 32'(ic.busy), 32'h0);
    ic.start = 1'b1;
    @(posedge clk); #1;
    ic.start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check("c_rerun_sig", 32'(ic.sig), 32'h03);
    check("c_rerun_pass", {30'd0, ic.done, ic.pass}, 32'h3);

    // Asynchronous reset in the middle of HOLD.
    ic.start = 1'b1;
    @(posedge clk); #1;
    ic.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("c_mid_stim", 32'(ic.stim), 32'h01);
    check("c_mid_sig", 32'(ic.sig), 32'h80);
    #2;
    rst_n = 1'b0;
    #1;
    check("c_arst_stim", 32'(ic.stim), 32'h0);
    check("c_arst_sig", 32'(ic.sig), 32'h0);
    check("c_arst_idx", 32'(ic.vec_idx), 32'h0);
    check("c_arst_flags", {29'd0, ic.busy, ic.done, ic.pass}, 32'h0);
    check("a_arst_flags", {29'd0, ia.busy, ia.done, ia.pass}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
